// File: rtl/serial_slice_sequencer.sv
// Bit-serial sequencer for a single-bit iterative cell: presents one operand bit pair per
// clock, feeds the registered chain bit back into the cell and collects U into a result word.
module serial_slice_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          K_INIT    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             k_final,
  output logic             cell_en,
  output logic             cell_x,
  output logic             cell_y,
  output logic             cell_k_in,
  input  logic             cell_u,
  input  logic             cell_k_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chain_q, chain_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             k_final_q, k_final_d;
  logic [CW-1:0]    pos;
  logic             last;

  assign pos  = LSB_FIRST ? cnt_q : (CW'(WIDTH - 1) - cnt_q);
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    chain_d   = chain_q;
    result_d  = result_q;
    k_final_d = k_final_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          chain_d  = K_INIT;
          result_d = '0;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (pos == CW'(i)) result_d[i] = cell_u;
        end
        chain_d = cell_k_out;
        cnt_d   = cnt_q + 1'b1;
        // Zero-fill shifting leaves both registers empty after WIDTH cycles, so the cell
        // inputs can come straight from the register bits and still read 0 outside RUN.
        if (LSB_FIRST) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
        end else begin
          a_d = a_q << 1;
          b_d = b_q << 1;
        end
        if (last) begin
          state_d   = StDone;
          k_final_d = cell_k_out;
          chain_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      chain_q   <= 1'b0;
      result_q  <= '0;
      k_final_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      chain_q   <= chain_d;
      result_q  <= result_d;
      k_final_q <= k_final_d;
    end
  end

  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign k_final   = k_final_q;
  assign cell_en   = (state_q == StRun);
  assign cell_x    = LSB_FIRST ? a_q[0] : a_q[WIDTH-1];
  assign cell_y    = LSB_FIRST ? b_q[0] : b_q[WIDTH-1];
  assign cell_k_in = chain_q;

endmodule

// File: tb/tb_serial_slice_sequencer.sv
// Bench: three sequencer variants (LSB/K0, LSB/K1, MSB/K0) each driving a full-adder cell,
// checked every cycle against an operation-level model plus literal and arithmetic expectations.
module tb_serial_slice_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a_in, b_in;

  logic       busy[3], done[3], en[3], cx[3], cy[3], ck[3], cu[3], cko[3], kf[3];
  logic [7:0] res[3];

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_slice_sequencer #(
      .WIDTH    (8),
      .LSB_FIRST(g != 2),
      .K_INIT   (g == 1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a_in),
      .b         (b_in),
      .busy      (busy[g]),
      .done      (done[g]),
      .result    (res[g]),
      .k_final   (kf[g]),
      .cell_en   (en[g]),
      .cell_x    (cx[g]),
      .cell_y    (cy[g]),
      .cell_k_in (ck[g]),
      .cell_u    (cu[g]),
      .cell_k_out(cko[g])
    );
    // Full-adder cell, gated by En
    assign cu[g]  = en[g] & (cx[g] ^ cy[g] ^ ck[g]);
    assign cko[g] = en[g] & ((cx[g] & cy[g]) | (cx[g] & ck[g]) | (cy[g] & ck[g]));
  end

  function automatic bit lsb_of(input int g);
    return g != 2;
  endfunction

  function automatic bit kinit_of(input int g);
    return g == 1;
  endfunction

  // Operation-level model: ph = -1 idle, 0..7 run cycle index, 8 done cycle
  int         ph = -1;
  logic [7:0] ma = '0, mb = '0;
  logic [7:0] mres[3] = '{default: 8'h00};
  logic       mkf[3]  = '{default: 1'b0};
  logic       mc[3]   = '{default: 1'b0};

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        ph = -1;
        for (int g = 0; g < 3; g++) begin
          mres[g] = '0;
          mkf[g]  = 1'b0;
          mc[g]   = 1'b0;
        end
      end else if (ph == -1) begin
        if (start) begin
          ph = 0;
          ma = a_in;
          mb = b_in;
          for (int g = 0; g < 3; g++) begin
            mres[g] = '0;
            mc[g]   = kinit_of(g);
          end
        end
      end else if (ph < 8) begin
        for (int g = 0; g < 3; g++) begin
          int p;
          int s;
          p = lsb_of(g) ? ph : 7 - ph;
          s = int'(ma[p]) + int'(mb[p]) + int'(mc[g]);
          mres[g][p] = s[0];
          mc[g] = s >= 2;
          if (ph == 7) mkf[g] = mc[g];
        end
        ph++;
      end else begin
        ph = -1;
      end
    end
  end

  // Per-cycle compare on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int g = 0; g < 3; g++) begin
          logic [13:0] exp_v, act_v;
          bit          run;
          int          p;
          run = (ph >= 0) && (ph < 8);
          p   = run ? (lsb_of(g) ? ph : 7 - ph) : 0;
          exp_v = {ph >= 0, ph == 8, run, run & ma[p], run & mb[p], run & mc[g], mres[g], mkf[g]};
          act_v = {busy[g], done[g], en[g], cx[g], cy[g], ck[g], res[g], kf[g]};
          total++;
          if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_compare inst=%0d t=%0t actual=%h required=%h", g, $time, act_v,
                     exp_v);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Runs one operation; returns the done latency in cycles after the start edge and the number
  // of cycles instance 0 had cell_en high. Ends at the falling edge of the following IDLE cycle.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit noise,
                       output int lat, output int en_cnt);
    a_in   = x;
    b_in   = y;
    start  = 1'b1;
    lat    = -1;
    en_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (en[0]) en_cnt++;
      if (done[0]) begin
        lat = k;
        if (noise) begin
          start = 1'b1;
          a_in  = 8'($urandom);
          b_in  = 8'($urandom);
        end
        break;
      end
      if (noise && (k % 3 == 0)) begin
        start = 1'b1;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int         lat, en_cnt;
    logic [7:0] x, y, r;
    logic [8:0] sum;
    logic       c;

    reset = 1'b1;
    start = 1'b1;
    a_in  = 8'hA5;
    b_in  = 8'h5A;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_result", int'(res[0]), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, lat, en_cnt);
    chk("op1_latency", lat, 9);
    chk("op1_en_cycles", en_cnt, 8);
    chk("op1_result", int'(res[0]), 'h96);
    chk("op1_kfinal", int'(kf[0]), 0);

    do_op(8'hFF, 8'h01, 1'b0, lat, en_cnt);
    chk("op2_result", int'(res[0]), 'h00);
    chk("op2_kfinal", int'(kf[0]), 1);

    do_op(8'h00, 8'h00, 1'b0, lat, en_cnt);
    chk("op3_kinit_result", int'(res[1]), 'h01);
    chk("op3_kinit_kfinal", int'(kf[1]), 0);

    do_op(8'h80, 8'h01, 1'b0, lat, en_cnt);
    chk("op4_msb_result", int'(res[2]), 'h81);
    chk("op4_msb_kfinal", int'(kf[2]), 0);

    do_op(8'h5A, 8'h3C, 1'b1, lat, en_cnt);
    chk("op5_noise_latency", lat, 9);
    chk("op5_noise_result", int'(res[0]), 'h96);

    // Reset during RUN cycle 4
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_en_before", int'(en[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_busy", int'(busy[0]), 0);
    chk("midrun_result", int'(res[0]), 0);
    chk("midrun_en", int'(en[0]), 0);
    repeat (10) begin
      @(negedge clk);
      chk("midrun_no_done", int'(done[0]), 0);
    end

    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      do_op(x, y, 1'($urandom_range(0, 1)), lat, en_cnt);
      chk("rand_latency", lat, 9);
      sum = {1'b0, x} + {1'b0, y};
      chk("rand_sum_lsb", int'({kf[0], res[0]}), int'(sum));
      sum = {1'b0, x} + {1'b0, y} + 9'd1;
      chk("rand_sum_kinit", int'({kf[1], res[1]}), int'(sum));
      c = 1'b0;
      r = '0;
      for (int p = 7; p >= 0; p--) begin
        r[p] = x[p] ^ y[p] ^ c;
        c    = (x[p] & y[p]) | (x[p] & c) | (y[p] & c);
      end
      chk("rand_msb_chain", int'({kf[2], res[2]}), int'({c, r}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_slice_sequencer.md
# serial_slice_sequencer

Bit-serial sequencer that sits directly upstream of the single-bit iterative cell (En, X, Y, K_in → U, K_out) and drives it one bit position per clock. It loads two WIDTH-bit operands, presents one bit pair per cycle with the registered chain bit fed back into K_in, and collects the cell's U outputs into a WIDTH-bit result. One cell instance thus does the work of a WIDTH-long ripple chain. The cell is external: this block only drives its inputs and samples its outputs.

## Interface
- WIDTH, 8, operand/result width; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 presented first; 0 = bit WIDTH-1 presented first.
- K_INIT, 0, value loaded into the chain register at start; drives cell_k_in in the first RUN cycle.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- a  in  WIDTH  operand driven onto cell_x; sampled on accepted start.
- b  in  WIDTH  operand driven onto cell_y; sampled on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- result  out  WIDTH  collected U bits; held until next accepted start.
- k_final  out  1  last K_out value; held like result.
- cell_en  out  1  to cell En; high only in RUN.
- cell_x  out  1  to cell X.
- cell_y  out  1  to cell Y.
- cell_k_in  out  1  to cell K_in.
- cell_u  in  1  from cell U; combinational in the same cycle.
- cell_k_out  in  1  from cell K_out; combinational in the same cycle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1. Same edge:
  - a and b are captured into shift registers.
  - bit counter is set to 0 and the chain register to K_INIT.
  - result is cleared to 0.
- RUN, cycle i (i = 0..WIDTH-1):
  - cell_en = 1 and cell_k_in = chain register.
  - Position p = i if LSB_FIRST = 1, else WIDTH-1-i.
  - cell_x = a[p] and cell_y = b[p], driven straight from shift-register bits (no logic in front of the cell).
  - At the cycle's end edge: result[p] ← cell_u, chain register ← cell_k_out, shift, counter + 1.
- RUN → DONE on the edge that ends cycle i = WIDTH-1. k_final ← cell_k_out on that edge.
- DONE → IDLE unconditionally after one cycle.
- Outside RUN: cell_en, cell_x, cell_y and cell_k_in are all 0.
- start is ignored in RUN and DONE, with no effect on any state.
- Counter width is clog2(WIDTH)+1 bits. Counter and shift registers never wrap within a run.
- Reset wins over every other event, including start in the same cycle and reset arriving mid-RUN. The partial result is discarded.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, k_final 0, all cell_* outputs 0, counter 0, chain register 0.
- start is sampled at edge E0. RUN occupies cycles E0+1 .. E0+WIDTH. done = 1 in cycle E0+WIDTH+1, when result and k_final are already valid.
- Earliest next accepted start is at edge E0+WIDTH+2, with the block back in IDLE. Throughput is one operation per WIDTH+2 cycles.
- busy rises in cycle E0+1 and falls after the DONE cycle.
- The cell path is cell_* out → cell → cell_u / cell_k_out in → register, all within one cycle.

## Test plan
Bench uses a full-adder model for the cell: U = X^Y^K_in, K_out = majority(X, Y, K_in), both gated by En. All scenarios use WIDTH = 8.
- Reset → busy, done, result, k_final and every cell_* output are 0. Holding start = 1 together with reset leaves the block in IDLE.
- LSB_FIRST = 1, K_INIT = 0, a = 0x5A, b = 0x3C → done in cycle E0+9, result = 0x96, k_final = 0. cell_en is high for exactly 8 cycles.
- a = 0xFF, b = 0x01 → result = 0x00, k_final = 1. cell_k_in is 0 in RUN cycle 0 and 1 in cycles 1..7.
- K_INIT = 1, a = 0x00, b = 0x00 → result = 0x01, k_final = 0.
- LSB_FIRST = 0, a = 0x80, b = 0x01 → cell_x = 1 only in RUN cycle 0, cell_y = 1 only in cycle 7. Chain register stays 0 for the whole run, so result = 0x81, k_final = 0.
- Start pulses during RUN and during DONE are ignored: result is unchanged from the first operation. Reset asserted in RUN cycle 4 → next cycle IDLE, result 0, no done pulse, cell_en 0.
